branch_recovery_ctrl: RTL and testbench
=======================================

Name: branch_recovery_ctrl

Overview:
Sequences pipeline recovery after the execute stage resolves a branch. It consumes the execute-stage resolution (taken decision, target, prediction-correct flag), issues the fetch redirect and a multi-cycle flush on a misprediction, and queues predictor-training updates toward the branch predictor through a small FIFO with a valid/ready handshake. It sits between the exe-stage prediction check and the fetch stage / branch predictor tables.

Parameters:
ADDR_W, 32, width of PC and target addresses
FLUSH_CYCLES, 2, cycles flush_o is held after a misprediction (legal range 1..15)
UPD_DEPTH, 4, predictor-update FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  core clock
rstn_i  in  1  synchronous active-low reset
exe_valid_i  in  1  execute-stage instruction valid
exe_is_branch_i  in  1  instruction is a conditional branch or JALR
exe_stall_i  in  1  execute stage stalled; resolution not final this cycle
exe_pc_i  in  ADDR_W  PC of the resolving instruction
taken_i  in  1  real branch decision
target_i  in  ADDR_W  real branch target
correct_pred_i  in  1  prediction correct flag from the exe-stage checker
flush_o  out  1  kill younger in-flight instructions
redirect_valid_o  out  1  one-cycle fetch redirect strobe
redirect_pc_o  out  ADDR_W  redirect address
upd_valid_o  out  1  predictor update available
upd_ready_i  in  1  predictor accepts update
upd_pc_o  out  ADDR_W  update PC
upd_taken_o  out  1  update decision
upd_target_o  out  ADDR_W  update target
upd_drop_o  out  1  one-cycle pulse: update discarded, FIFO full
mispred_cnt_o  out  16  saturating misprediction count

Behaviour:
- Reset (rstn_i=0 at a rising edge): state IDLE; all outputs 0; FIFO empty; flush counter 0; mispred_cnt_o=0. Reset mid-flush aborts the flush immediately, and FIFO contents are discarded.
- Resolution event (res) = exe_valid_i & !exe_stall_i & state==IDLE. Mispredict (mp) = res & !correct_pred_i. Inputs are ignored in FLUSH because they are wrong-path.
- FSM states IDLE and FLUSH.
  - IDLE -> FLUSH on mp.
  - FLUSH holds while the flush counter < FLUSH_CYCLES, then returns to IDLE.
  - Timing: mp sampled at edge N. flush_o=1 in cycles N+1..N+FLUSH_CYCLES. The block is back in IDLE and accepts res in cycle N+FLUSH_CYCLES+1.
- Redirect: redirect_valid_o=1 only in cycle N+1.
  - redirect_pc_o = target_i if taken_i, else exe_pc_i+4 (both registered at edge N). Addition wraps modulo 2^ADDR_W.
  - redirect_pc_o holds its last value while redirect_valid_o=0.
- mispred_cnt_o increments on each mp and saturates at 16'hFFFF.
- Update FIFO:
  - Push on res & exe_is_branch_i, for correct and mispredicted branches alike. Entry = {exe_pc_i, taken_i, target_i}.
  - Pop on upd_valid_o & upd_ready_i.
  - upd_valid_o = !empty. Outputs are the head entry, registered, so a push at edge N is visible in cycle N+1 at the earliest. Head outputs are stable while upd_valid_o=1 & !upd_ready_i.
  - Full with push and no pop: the entry is dropped, upd_drop_o=1 the next cycle, and the FIFO is unchanged.
  - Full with push and pop in the same cycle: both are accepted and the count stays at UPD_DEPTH.
  - Empty with push: there is no same-cycle bypass.
  - Read and write pointers wrap modulo UPD_DEPTH; an extra pointer bit distinguishes full from empty.
- exe_stall_i=1 blocks both push and mp evaluation; flush progress is not affected by stall.
- Non-branch instructions with correct_pred_i=0 still trigger recovery. They do not push an update.

Test Plan:
- Correct branch: pc=0x100, taken=1, target=0x200, correct=1 -> flush_o stays 0; upd_valid_o=1 next cycle with {0x100,1,0x200}; mispred_cnt_o=0.
- Mispredict not-taken: pc=0x1000, taken=0, correct=0 at edge N -> redirect_valid_o=1, redirect_pc_o=0x1004 at N+1; flush_o=1 for N+1..N+2; a second mispredict presented at N+1 is ignored; mispred_cnt_o=1.
- Wrap: pc=0xFFFFFFFC, taken=0, correct=0 -> redirect_pc_o=0x00000000.
- FIFO full: upd_ready_i=0, push 5 branches -> 4 held, upd_drop_o pulses once; then upd_ready_i=1 drains them in push order; a push during the full+pop cycle is accepted.
- Stall: exe_stall_i=1 with correct=0 -> no flush, no push; deassert stall -> recovery starts on the next edge.
- Reset mid-flush: rstn_i=0 in cycle N+1 -> flush_o=0, upd_valid_o=0, mispred_cnt_o=0 the following cycle; saturation check: preload 0xFFFF mispredicts -> counter holds 0xFFFF.

Source files
------------

// File: rtl/branch_recovery_ctrl.sv
// Branch recovery sequencer: turns an execute-stage mispredict into a fetch redirect
// plus a multi-cycle flush, and queues predictor-training updates through a small FIFO.
module branch_recovery_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int UPD_DEPTH    = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              exe_valid_i,
    input  logic              exe_is_branch_i,
    input  logic              exe_stall_i,
    input  logic [ADDR_W-1:0] exe_pc_i,
    input  logic              taken_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              correct_pred_i,
    output logic              flush_o,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              upd_valid_o,
    input  logic              upd_ready_i,
    output logic [ADDR_W-1:0] upd_pc_o,
    output logic              upd_taken_o,
    output logic [ADDR_W-1:0] upd_target_o,
    output logic              upd_drop_o,
    output logic [15:0]       mispred_cnt_o
);

    localparam int PTR_W = $clog2(UPD_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              taken;
        logic [ADDR_W-1:0] target;
    } upd_t;

    state_t            state_q, state_d;
    logic [3:0]        flush_cnt_q, flush_cnt_d;
    logic              res, mp;
    logic              redirect_valid_q;
    logic [ADDR_W-1:0] redirect_pc_q;
    logic [15:0]       mispred_cnt_q;

    upd_t              mem_q [UPD_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic              fifo_full, fifo_empty;
    logic              push_req, push_ok, pop;
    logic              drop_q;
    upd_t              head;

    // Anything arriving while flushing is wrong-path and must not be acted on.
    assign res = exe_valid_i & ~exe_stall_i & (state_q == IDLE);
    assign mp  = res & ~correct_pred_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            flush_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // flush_cnt_q counts flush cycles already presented, starting at 1 in the first one.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (mp) begin
                    state_d     = FLUSH;
                    flush_cnt_d = 4'd1;
                end
            end
            FLUSH: begin
                if (flush_cnt_q < 4'(FLUSH_CYCLES)) begin
                    flush_cnt_d = flush_cnt_q + 4'd1;
                end else begin
                    state_d     = IDLE;
                    flush_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d     = IDLE;
                flush_cnt_d = 4'd0;
            end
        endcase
    end

    assign flush_o = (state_q == FLUSH);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mispred_cnt_q    <= 16'd0;
        end else begin
            redirect_valid_q <= mp;
            if (mp) begin
                redirect_pc_q <= taken_i ? target_i : exe_pc_i + ADDR_W'(4);
                if (mispred_cnt_q != 16'hFFFF) begin
                    mispred_cnt_q <= mispred_cnt_q + 16'd1;
                end
            end
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign mispred_cnt_o    = mispred_cnt_q;

    // Update port handshake: an entry transfers on a cycle where upd_valid_o & upd_ready_i;
    // while upd_valid_o=1 and upd_ready_i=0 the head entry is held unchanged.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push_req   = res & exe_is_branch_i;
    assign pop        = ~fifo_empty & upd_ready_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok    = push_req & (~fifo_full | pop);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= 1'b0;
            for (int i = 0; i < UPD_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            drop_q <= push_req & fifo_full & ~pop;
            if (push_ok) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= '{pc: exe_pc_i, taken: taken_i, target: target_i};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign head         = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign upd_valid_o  = ~fifo_empty;
    assign upd_pc_o     = head.pc;
    assign upd_taken_o  = head.taken;
    assign upd_target_o = head.target;
    assign upd_drop_o   = drop_q;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed bench for branch_recovery_ctrl: redirect/flush timing, FIFO order,
// full/drop behaviour, stall gating, reset abort and counter saturation.
module tb_branch_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        exe_valid, exe_is_branch, exe_stall, taken, correct_pred;
    logic [31:0] exe_pc, target;
    logic        flush, redirect_valid, upd_valid, upd_ready, upd_taken, upd_drop;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [15:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    branch_recovery_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .UPD_DEPTH(4)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .exe_valid_i      (exe_valid),
        .exe_is_branch_i  (exe_is_branch),
        .exe_stall_i      (exe_stall),
        .exe_pc_i         (exe_pc),
        .taken_i          (taken),
        .target_i         (target),
        .correct_pred_i   (correct_pred),
        .flush_o          (flush),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .upd_valid_o      (upd_valid),
        .upd_ready_i      (upd_ready),
        .upd_pc_o         (upd_pc),
        .upd_taken_o      (upd_taken),
        .upd_target_o     (upd_target),
        .upd_drop_o       (upd_drop),
        .mispred_cnt_o    (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic br, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tgt, input logic ok);
        exe_valid     = v;
        exe_is_branch = br;
        exe_pc        = pc;
        taken         = tk;
        target        = tgt;
        correct_pred  = ok;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc,
                              input logic tk, input logic [31:0] tgt);
        check({tag, "_valid"}, upd_valid, 1'b1);
        check({tag, "_pc"}, upd_pc, pc);
        check({tag, "_taken"}, upd_taken, tk);
        check({tag, "_target"}, upd_target, tgt);
    endtask

    initial begin
        rstn      = 1'b0;
        exe_stall = 1'b0;
        upd_ready = 1'b0;
        idle_in();
        step();
        step();
        check("rst_flush", flush, 1'b0);
        check("rst_redir_v", redirect_valid, 1'b0);
        check("rst_redir_pc", redirect_pc, 32'h0);
        check("rst_upd_v", upd_valid, 1'b0);
        check("rst_upd_pc", upd_pc, 32'h0);
        check("rst_drop", upd_drop, 1'b0);
        check("rst_cnt", mispred_cnt, 16'd0);
        rstn = 1'b1;
        step();

        // Correctly predicted branch: update only, no recovery.
        drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
        step();
        idle_in();
        check("ok_flush", flush, 1'b0);
        check("ok_redir_v", redirect_valid, 1'b0);
        check_head("ok_upd", 32'h100, 1'b1, 32'h200);
        check("ok_cnt", mispred_cnt, 16'd0);
        upd_ready = 1'b1;
        step();
        upd_ready = 1'b0;
        check("ok_drained", upd_valid, 1'b0);

        // Not-taken mispredict; a second one during the flush is wrong-path.
        drive(1'b1, 1'b1, 32'h1000, 1'b0, 32'h5555, 1'b0);
        step();
        check("mp_redir_v", redirect_valid, 1'b1);
        check("mp_redir_pc", redirect_pc, 32'h1004);
        check("mp_flush1", flush, 1'b1);
        check("mp_cnt1", mispred_cnt, 16'd1);
        check_head("mp_upd", 32'h1000, 1'b0, 32'h5555);
        drive(1'b1, 1'b1, 32'h2000, 1'b1, 32'h3000, 1'b0);
        step();
        idle_in();
        check("mp_flush2", flush, 1'b1);
        check("mp_redir_v2", redirect_valid, 1'b0);
        check("mp_redir_hold", redirect_pc, 32'h1004);
        check("mp_cnt_ign", mispred_cnt, 16'd1);
        step();
        check("mp_flush_end", flush, 1'b0);
        upd_ready = 1'b1;
        step();
        upd_ready = 1'b0;
        check("mp_one_entry", upd_valid, 1'b0);

        // Non-branch mispredict at the top of the address space: wraps, no update.
        drive(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h1234, 1'b0);
        step();
        idle_in();
        check("wrap_redir_v", redirect_valid, 1'b1);
        check("wrap_redir_pc", redirect_pc, 32'h0);
        check("wrap_no_upd", upd_valid, 1'b0);
        check("wrap_cnt", mispred_cnt, 16'd2);
        step();
        step();
        check("wrap_idle", flush, 1'b0);

        // Taken mispredict redirects to the real target.
        drive(1'b1, 1'b0, 32'h300, 1'b1, 32'h480, 1'b0);
        step();
        idle_in();
        check("tk_redir_pc", redirect_pc, 32'h480);
        check("tk_cnt", mispred_cnt, 16'd3);
        step();
        step();

        // Fill the FIFO with the ready held low; the fifth push is dropped.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'h400 + 32'(4 * i), 1'(i), 32'h800 + 32'(i), 1'b1);
            step();
            check($sformatf("full_drop%0d", i), upd_drop, (i == 4) ? 1'b1 : 1'b0);
        end
        idle_in();
        step();
        check("full_drop_once", upd_drop, 1'b0);
        check_head("full_head0", 32'h400, 1'b0, 32'h800);
        // Full with pop and push together: both go through.
        drive(1'b1, 1'b1, 32'h414, 1'b1, 32'h805, 1'b1);
        upd_ready = 1'b1;
        step();
        idle_in();
        check("fullpop_drop", upd_drop, 1'b0);
        check_head("drain1", 32'h404, 1'b1, 32'h801);
        step();
        check_head("drain2", 32'h408, 1'b0, 32'h802);
        step();
        check_head("drain3", 32'h40C, 1'b1, 32'h803);
        step();
        check_head("drain5", 32'h414, 1'b1, 32'h805);
        step();
        check("drain_empty", upd_valid, 1'b0);
        upd_ready = 1'b0;

        // Stall blocks both recovery and push until released.
        exe_stall = 1'b1;
        drive(1'b1, 1'b1, 32'h900, 1'b1, 32'hA00, 1'b0);
        step();
        check("stall_flush", flush, 1'b0);
        check("stall_redir_v", redirect_valid, 1'b0);
        check("stall_upd", upd_valid, 1'b0);
        check("stall_cnt", mispred_cnt, 16'd3);
        exe_stall = 1'b0;
        step();
        idle_in();
        check("unstall_flush", flush, 1'b1);
        check("unstall_redir_pc", redirect_pc, 32'hA00);
        check("unstall_cnt", mispred_cnt, 16'd4);
        check_head("unstall_upd", 32'h900, 1'b1, 32'hA00);

        // Reset in the first flush cycle aborts everything, queued updates included.
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("rmid_flush", flush, 1'b0);
        check("rmid_upd", upd_valid, 1'b0);
        check("rmid_cnt", mispred_cnt, 16'd0);
        check("rmid_redir_v", redirect_valid, 1'b0);

        // Saturation: start the counter just below the top.
        force dut.mispred_cnt_q = 16'hFFFE;
        #1;
        release dut.mispred_cnt_q;
        drive(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0);
        step();
        idle_in();
        check("sat_top", mispred_cnt, 16'hFFFF);
        step();
        step();
        drive(1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0);
        step();
        idle_in();
        check("sat_hold", mispred_cnt, 16'hFFFF);
        check("sat_redir_pc", redirect_pc, 32'h84);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
